// File: rtl/score_bcd_sched_pkg.sv
// Shared types and constants for the score-to-BCD conversion scheduler.
// Defaults size the datapath for an 8-digit decimal score display.
package score_bcd_sched_pkg;
  localparam int DEF_BIN_W  = 27;
  localparam int DEF_DIGITS = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic [63:0] max_val(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_val(DEF_DIGITS);
  localparam logic [4*DEF_DIGITS-1:0] BCD_NINE_ALL = {DEF_DIGITS{4'h9}};
endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift {bcd,bin} left by one.
// Purely combinational; digit adds wrap at 4 bits and the shifted-out BCD MSB is dropped.
module bcd_dabble_step
  import score_bcd_sched_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic [BIN_W-1:0]    bin_in,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [BIN_W-1:0]    bin_out
);
  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = bcd_in;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_in[4*d +: 4] + 4'd3;
    end
    bcd_out = {adj[4*DIGITS-2:0], bin_in[BIN_W-1]};
    bin_out = {bin_in[BIN_W-2:0], 1'b0};
  end
endmodule

// File: rtl/score_bcd_sched.sv
// Round-robin shares one sequential double-dabble converter between live (0) and best (1) scores.
// Result registers load on the last shift edge so bcd_out is already new while out_valid is high.
module score_bcd_sched
  import score_bcd_sched_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [BIN_W-1:0]    bin0,
  input  logic [BIN_W-1:0]    bin1,
  output logic [1:0]          grant,
  output logic                busy,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                out_tag,
  output logic                out_valid,
  output logic                ovf
);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0] MAX_V = max_val(DIGITS);
  localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};

  state_t              state, state_nxt;
  logic                rr_ptr, win, tag_q, ovf_q;
  logic [CNT_W-1:0]    cnt;
  logic [BIN_W-1:0]    bin_sh, bin_sel, step_bin;
  logic [4*DIGITS-1:0] bcd_sh, step_bcd;

  bcd_dabble_step #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_step (
    .bcd_in  (bcd_sh),
    .bin_in  (bin_sh),
    .bcd_out (step_bcd),
    .bin_out (step_bin)
  );

  always_comb begin
    state_nxt = state;
    grant     = 2'b00;
    win       = req[rr_ptr] ? rr_ptr : ~rr_ptr;
    bin_sel   = win ? bin1 : bin0;
    busy      = (state != S_IDLE);
    out_valid = (state == S_DONE);
    case (state)
      S_IDLE: begin
        if (|req) begin
          grant[win] = 1'b1;
          state_nxt  = S_SHIFT;
        end
      end
      S_SHIFT: if (cnt == CNT_W'(1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      rr_ptr  <= 1'b0;
      cnt     <= '0;
      bin_sh  <= '0;
      bcd_sh  <= '0;
      tag_q   <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_out <= '0;
      out_tag <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (|req) begin
            bin_sh <= bin_sel;
            bcd_sh <= '0;
            cnt    <= CNT_W'(BIN_W);
            tag_q  <= win;
            ovf_q  <= ({{(64-BIN_W){1'b0}}, bin_sel} > MAX_V);
          end
        end
        S_SHIFT: begin
          bcd_sh <= step_bcd;
          bin_sh <= step_bin;
          cnt    <= cnt - CNT_W'(1);
          // Final shift lands directly in the output registers so they are valid during DONE.
          if (cnt == CNT_W'(1)) begin
            bcd_out <= ovf_q ? NINES : step_bcd;
            out_tag <= tag_q;
            ovf     <= ovf_q;
          end
        end
        S_DONE:  rr_ptr <= ~tag_q;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_score_bcd_sched.sv
// Randomized scoreboard bench for score_bcd_sched against a decimal-arithmetic reference model.
module tb_score_bcd_sched;
  localparam int BIN_W = 27;
  localparam int LAT   = BIN_W + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [26:0] bin0, bin1;
  logic [1:0]  grant;
  logic        busy, out_tag, out_valid, ovf;
  logic [31:0] bcd_out;

  typedef struct {
    logic [31:0] bcd;
    logic        tag;
    logic        ovf;
    int          gcyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rr_m = 1'b0;

  score_bcd_sched dut (
    .clk(clk), .rst(rst), .req(req), .bin0(bin0), .bin1(bin1),
    .grant(grant), .busy(busy), .bcd_out(bcd_out), .out_tag(out_tag),
    .out_valid(out_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_bcd(input longint unsigned v);
    logic [31:0] r;
    longint unsigned x;
    r = '0;
    if (v > 64'd99999999) return 32'h99999999;
    x = v;
    for (int d = 0; d < 8; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  // Monitor: predicts arbitration and pushes expectations on grant; pops and compares on out_valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (grant != 2'b00) begin
        logic w;
        exp_t e;
        w = req[rr_m] ? rr_m : ~rr_m;
        chk("grant_winner", grant, (w ? 2'b10 : 2'b01));
        chk("grant_while_busy", busy, 0);
        e.bcd  = ref_bcd(w ? bin1 : bin0);
        e.tag  = w;
        e.ovf  = ((w ? bin1 : bin0) > 27'd99999999);
        e.gcyc = cyc;
        exp_q.push_back(e);
      end else if (!busy && req != 2'b00) begin
        chk("idle_req_no_grant", grant, 1);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", out_valid, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("bcd_out", bcd_out, e.bcd);
          chk("out_tag", out_tag, e.tag);
          chk("ovf", ovf, e.ovf);
          chk("latency", cyc - e.gcyc, LAT);
          rr_m = ~e.tag;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_grant", grant, 0);
    exp_q.delete();
    rr_m = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_grant(output logic [1:0] g);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (grant == 2'b00 && t < 100);
    g = grant;
    if (g == 2'b00) chk("grant_timeout", 0, 1);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0 || busy) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] pat, input logic [26:0] b0, input logic [26:0] b1,
                       input int ngr, input bit held, input bit scramble);
    logic [1:0] g;
    bin0 = b0;
    bin1 = b1;
    req  = pat;
    for (int k = 0; k < ngr; k++) begin
      wait_grant(g);
      @(posedge clk);
      #1;
      if (held) begin
        if (k == ngr - 1) req = 2'b00;
      end else begin
        req = req & ~g;
        if (scramble && g[0]) bin0 = 27'($urandom);
        if (scramble && g[1]) bin1 = 27'($urandom);
      end
    end
    drain();
  endtask

  function automatic logic [26:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 27'($urandom_range(0, 99999999));
      1:       return 27'($urandom_range(99999990, 100000010));
      2:       return 27'($urandom);
      default: return 27'($urandom_range(0, 999));
    endcase
  endfunction

  initial begin
    logic [1:0] g;
    logic [1:0] pat;
    rst  = 1'b1;
    req  = 2'b00;
    bin0 = '0;
    bin1 = '0;
    @(posedge clk);
    do_reset();

    issue(2'b01, 27'd2048, 27'd0, 1, 1'b0, 1'b0);
    do_reset();
    issue(2'b11, 27'd9, 27'd131072, 2, 1'b0, 1'b0);
    issue(2'b01, 27'd99999999, 27'd0, 1, 1'b0, 1'b0);
    issue(2'b01, 27'd100000000, 27'd0, 1, 1'b0, 1'b0);
    issue(2'b01, 27'd0, 27'd0, 1, 1'b0, 1'b0);

    // Abort a conversion partway through the shift phase.
    bin0 = 27'd1234567;
    req  = 2'b01;
    wait_grant(g);
    @(posedge clk);
    #1 req = 2'b00;
    repeat (9) @(posedge clk);
    #1 chk("busy_mid_shift", busy, 1);
    do_reset();
    repeat (40) @(negedge clk);
    issue(2'b01, 27'd512, 27'd0, 1, 1'b0, 1'b0);

    issue(2'b11, 27'd11111, 27'd22222, 4, 1'b1, 1'b0);
    issue(2'b01, 27'd4096, 27'd0, 1, 1'b0, 1'b1);
    issue(2'b10, 27'd0, 27'h7FFFFFF, 1, 1'b0, 1'b0);

    for (int n = 0; n < 16; n++) begin
      pat = 2'($urandom_range(1, 3));
      issue(pat, rand_val(), rand_val(), (pat == 2'b11) ? 2 : 1, 1'b0, 1'b1);
    end

    chk("queue_empty_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
